// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: DMCtrl access-width encodings and the
// access sequencer state type.
package dmem_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load extraction with sign/zero extension, and access legality.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rext,
    output logic        legal
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        legal = 1'b0;
        be    = 4'b0000;
        wlane = wdata;
        rext  = word;
        case (ctrl)
            DM_B: begin
                legal = 1'b1;
                be    = 4'b0001 << addr_lo;
                wlane = {4{wdata[7:0]}};
                rext  = {{24{sel_byte[7]}}, sel_byte};
            end
            DM_BU: begin
                // Unsigned widths only make sense for loads
                legal = !we;
                be    = 4'b0001 << addr_lo;
                rext  = {24'd0, sel_byte};
            end
            DM_H: begin
                legal = !addr_lo[0];
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                rext  = {{16{sel_half[15]}}, sel_half};
            end
            DM_HU: begin
                legal = !addr_lo[0] && !we;
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                rext  = {16'd0, sel_half};
            end
            DM_W: begin
                legal = (addr_lo == 2'b00);
                be    = 4'b1111;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: captures a core load/store, drives the
// req/gnt/rvalid handshake, stalls the core until the access retires.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_en,
    input  logic        core_we,
    input  logic [2:0]  core_ctrl,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [2:0]       ctrl_q;
    logic [31:0]      addr_q;

    logic             al_we;
    logic [2:0]       al_ctrl;
    logic [1:0]       al_addr;
    logic [3:0]       al_be;
    logic [31:0]      al_wlane, al_rext;
    logic             al_legal;
    logic             capture, timeout;

    // In IDLE the live core request is aligned; afterwards the captured copy
    assign al_we   = (state_q == ST_IDLE) ? core_we        : we_q;
    assign al_ctrl = (state_q == ST_IDLE) ? core_ctrl      : ctrl_q;
    assign al_addr = (state_q == ST_IDLE) ? core_addr[1:0] : addr_q[1:0];

    dmem_lane_align u_align (
        .we      (al_we),
        .ctrl    (al_ctrl),
        .addr_lo (al_addr),
        .wdata   (core_wdata),
        .word    (mem_rdata),
        .be      (al_be),
        .wlane   (al_wlane),
        .rext    (al_rext),
        .legal   (al_legal)
    );

    assign capture  = (state_q == ST_IDLE) && core_en;
    assign timeout  = TO_EN && (cnt_q >= TO_LAST);
    assign stall    = core_en && (state_q != ST_DONE);
    assign mem_addr = addr_q[31:2];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (core_en) state_d = al_legal ? ST_REQ : ST_DONE;
            // A grant wins over a coincident rvalid or timeout
            ST_REQ: begin
                if (mem_gnt)      state_d = ST_WAIT;
                else if (timeout) state_d = ST_DONE;
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            rdata   <= 32'd0;
            err     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mem_req <= (state_d == ST_REQ);
            if (capture) begin
                mem_we <= core_we && al_legal;
                mem_be <= al_legal ? al_be : 4'b0000;
                rdata  <= 32'd0;
                err    <= !al_legal;
                cnt_q  <= '0;
            end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (state_q == ST_WAIT && mem_rvalid)
                    rdata <= we_q ? 32'd0 : al_rext;
                else if (state_d == ST_DONE)
                    err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            we_q      <= core_we;
            ctrl_q    <= core_ctrl;
            addr_q    <= core_addr;
            mem_wdata <= al_wlane;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: table of load/store vectors against a
// scripted memory responder, plus reset-in-flight and hold sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_en, core_we;
    logic [2:0]  core_ctrl;
    logic [31:0] core_addr, core_wdata;
    logic        stall, err, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_en    (core_en),
        .core_we    (core_we),
        .core_ctrl  (core_ctrl),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        bit          we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          gnt_wait;
        int          rv_wait;
        bit          rv_with_gnt;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_req;
        int          exp_stall;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT in IDLE; returns at the negedge after DONE
    task automatic run(input int idx, input vec_t v);
        int  stall_n = 0;
        int  req_n   = 0;
        int  wait_n  = 0;
        bit  granted = 0;
        bit  done    = 0;
        core_en    = 1'b1;
        core_we    = v.we;
        core_ctrl  = v.ctrl;
        core_addr  = v.addr;
        core_wdata = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0BAD_F00D;
            #1;
            if (stall) begin
                stall_n++;
                if (mem_req) begin
                    if (req_n == 0) begin
                        chk($sformatf("v%0d mem_addr", idx), {2'b00, mem_addr}, {2'b00, v.addr[31:2]});
                        chk($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.we});
                        if (v.we) begin
                            chk($sformatf("v%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.exp_be});
                            chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_mwdata);
                        end
                    end
                    req_n++;
                    if (req_n > v.gnt_wait) begin
                        mem_gnt = 1'b1;
                        granted = 1'b1;
                        if (v.rv_with_gnt) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = 32'hDEAD_0000;
                        end
                    end
                end else if (granted) begin
                    if (wait_n == v.rv_wait) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.word;
                    end
                    wait_n++;
                end
            end else begin
                done = 1'b1;
                chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
                chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
                chk($sformatf("v%0d req_in_done", idx), {31'd0, mem_req}, 32'd0);
            end
            @(negedge clk);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk($sformatf("v%0d completed", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d stall_cycles", idx), stall_n, v.exp_stall);
        chk($sformatf("v%0d req_cycles", idx), req_n, v.exp_req);
    endtask

    initial begin
        //         we  ctrl  addr          wdata         word          gw   rw rvg be       mwdata        rdata         err req st
        tbl[0]  = '{1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0,   0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1, 3};
        tbl[1]  = '{0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0,   0, 0, 4'b0000, 32'h0,         32'hFFFF_FF80, 0, 1, 3};
        tbl[2]  = '{0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0,   0, 0, 4'b0000, 32'h0,         32'h0000_0080, 0, 1, 3};
        tbl[3]  = '{1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0,         0,   0, 0, 4'b1100, 32'h1234_1234, 32'h0000_0000, 0, 1, 3};
        tbl[4]  = '{0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0,   0, 0, 4'b0000, 32'h0,         32'h0000_0000, 1, 0, 1};
        tbl[5]  = '{0, 3'b010, 32'h0000_0200, 32'h0,         32'h0,         255, 0, 0, 4'b0000, 32'h0,         32'h0000_0000, 1, 4, 5};
        tbl[6]  = '{1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,         0,   0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000, 0, 1, 3};
        tbl[7]  = '{0, 3'b001, 32'h0000_0106, 32'h0,         32'h8001_7FFF, 1,   0, 0, 4'b0000, 32'h0,         32'hFFFF_8001, 0, 2, 4};
        tbl[8]  = '{0, 3'b101, 32'h0000_0106, 32'h0,         32'h8001_7FFF, 0,   0, 1, 4'b0000, 32'h0,         32'h0000_8001, 0, 1, 3};
        tbl[9]  = '{0, 3'b010, 32'h0000_010C, 32'h0,         32'h1234_5678, 0,   1, 0, 4'b0000, 32'h0,         32'h1234_5678, 0, 1, 4};
        tbl[10] = '{0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0,   0, 0, 4'b0000, 32'h0,         32'h0000_0000, 1, 0, 1};
        tbl[11] = '{1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         0,   0, 0, 4'b0000, 32'h0,         32'h0000_0000, 1, 0, 1};
        tbl[12] = '{0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         0,   0, 0, 4'b0000, 32'h0,         32'h0000_0000, 1, 0, 1};
        tbl[13] = '{1, 3'b001, 32'h0000_0100, 32'hFFFF_ABCD, 32'h0,         0,   0, 0, 4'b0011, 32'hABCD_ABCD, 32'h0000_0000, 0, 1, 3};
        tbl[14] = '{0, 3'b000, 32'h0000_0102, 32'h0,         32'h007F_0000, 0,   0, 0, 4'b0000, 32'h0,         32'h0000_007F, 0, 1, 3};

        rst = 1'b1; core_en = 1'b0; core_we = 1'b0; core_ctrl = 3'b000;
        core_addr = 32'h0; core_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // core_en stays high between vectors: back-to-back accesses
        for (int i = 0; i < 15; i++) run(i, tbl[i]);

        core_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("hold rdata", rdata, 32'h0000_007F);
        chk("hold err", {31'd0, err}, 32'd0);
        chk("idle stall", {31'd0, stall}, 32'd0);
        chk("idle mem_req", {31'd0, mem_req}, 32'd0);

        // Reset while waiting for a response; late rvalid must be ignored
        @(negedge clk);
        core_en = 1'b1; core_we = 1'b0; core_ctrl = 3'b010; core_addr = 32'h0000_0300;
        @(negedge clk);
        #1;
        chk("rstwait req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("rstwait in_wait", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstwait req_after", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        core_en = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rstwait stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late rv rdata", rdata, 32'd0);
        chk("late rv err", {31'd0, err}, 32'd0);
        chk("late rv req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        run(100, tbl[0]);
        run(101, tbl[1]);
        core_en = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
